// File: rtl/arb8_pri_sched_if.sv
// Request/grant bundle between eight requesters, the scheduler and the shared datapath.
// Signal names follow the 74148-style pinout the requesters already use.
interface arb8_pri_sched_if;
    logic       iEI;
    logic [7:0] iReq;
    logic       iDone;
    logic [7:0] oGnt;
    logic [2:0] oGntId;
    logic       oBusy;
    logic       oEO;
    logic       oTimeout;

    modport master (
        output iEI, iReq, iDone,
        input  oGnt, oGntId, oBusy, oEO, oTimeout
    );

    modport slave (
        input  iEI, iReq, iDone,
        output oGnt, oGntId, oBusy, oEO, oTimeout
    );
endinterface

// File: rtl/arb8_pri_sched.sv
// 8-channel scheduler: latches active-low requests, grants one owner at a time,
// releases on done or timeout and inserts one turnaround cycle between grants.
module arb8_pri_sched #(
    parameter int unsigned RR_MODE = 0,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              iClk,
    input  logic              iRst_n,
    arb8_pri_sched_if.slave   bus
);

    localparam int unsigned N_CH  = 8;
    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [N_CH-1:0]  pend, pend_nxt;
    logic [N_CH-1:0]  gnt, gnt_nxt;
    logic [ID_W-1:0]  gnt_id, gnt_id_nxt;
    logic             busy, busy_nxt;
    logic             tout, tout_nxt;
    logic [ID_W-1:0]  last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_CH-1:0]  clr;
    logic [ID_W-1:0]  win;
    logic             win_vld;

    // Winner pick: later loop iterations override earlier ones, so the
    // iteration order encodes priority (highest index, or last-1 first).
    always_comb begin : pick
        logic [ID_W-1:0] idx;
        idx     = '0;
        win     = '0;
        win_vld = |pend;
        if (RR_MODE == 0) begin
            for (int i = 0; i < N_CH; i++) begin
                if (pend[i]) win = ID_W'(i);
            end
        end else begin
            for (int i = N_CH; i >= 1; i--) begin
                idx = last - ID_W'(i);
                if (pend[idx]) win = idx;
            end
        end
    end

    always_comb begin : fsm_next
        state_nxt  = state;
        gnt_nxt    = gnt;
        gnt_id_nxt = gnt_id;
        busy_nxt   = busy;
        tout_nxt   = 1'b0;
        last_nxt   = last;
        cnt_nxt    = cnt;
        clr        = '0;
        case (state)
            S_IDLE: begin
                if (!bus.iEI && win_vld) begin
                    clr        = N_CH'(1) << win;
                    gnt_nxt    = N_CH'(1) << win;
                    gnt_id_nxt = win;
                    busy_nxt   = 1'b1;
                    last_nxt   = win;
                    cnt_nxt    = '0;
                    state_nxt  = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_nxt = cnt + 1'b1;
                // Done takes precedence over a coincident timeout.
                if (bus.iDone) begin
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = S_GAP;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    tout_nxt  = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // A request still held low re-pends in the same edge it is cleared.
        pend_nxt = (pend & ~clr) | ~bus.iReq;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state  <= S_IDLE;
            pend   <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            tout   <= 1'b0;
            last   <= ID_W'(N_CH - 1);
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            pend   <= pend_nxt;
            gnt    <= gnt_nxt;
            gnt_id <= gnt_id_nxt;
            busy   <= busy_nxt;
            tout   <= tout_nxt;
            last   <= last_nxt;
            cnt    <= cnt_nxt;
        end
    end

    assign bus.oGnt     = gnt;
    assign bus.oGntId   = gnt_id;
    assign bus.oBusy    = busy;
    assign bus.oTimeout = tout;
    assign bus.oEO      = ~(~bus.iEI && (pend == '0) && (state == S_IDLE));

endmodule
